db_load_responder: RTL

//  Serves database-chunk load requests from the seed-extension FSM (load/outAddress ->

---
 rtl/db_load_responder_if.sv | 30 +++
 rtl/db_load_responder.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/db_load_responder_if.sv
// Request/memory-side bundle for the database chunk load responder.
// The slave modport is the responder's view; master is the requester/memory side.
interface db_load_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 512
);
    logic              load;
    logic [ADDR_W-1:0] outAddress;
    logic              stop;
    logic              loadDone;
    logic              dataValid;
    logic [DATA_W-1:0] inDB;
    logic              oorErr;
    logic              memRdReq;
    logic [ADDR_W-1:0] memRdAddr;
    logic              memRdAck;
    logic              memRdValid;
    logic [DATA_W-1:0] memRdData;
    logic [16:0]       reqCount;

    modport slave (
        input  load, outAddress, stop, memRdAck, memRdValid, memRdData,
        output loadDone, dataValid, inDB, oorErr, memRdReq, memRdAddr, reqCount
    );

    modport master (
        output load, outAddress, stop, memRdAck, memRdValid, memRdData,
        input  loadDone, dataValid, inDB, oorErr, memRdReq, memRdAddr, reqCount
    );
endinterface

// File: rtl/db_load_responder.sv
// Turns each chunk load request into a single 512-bit memory read and hands the
// chunk back to the requester: loadDone first, dataValid with the data afterwards.
// Out-of-range indices are answered with a zero chunk and oorErr, without a read.
module db_load_responder #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 512,
    parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}},
    parameter int                DB_WORDS  = 131072
) (
    input  logic                 clk,
    input  logic                 rst,
    db_load_responder_if.slave   bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DELIVER = 2'd3;

    // One extra bit so a DB_WORDS equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DB_LIMIT = (ADDR_W+1)'(DB_WORDS);

    logic [1:0]        state_q,      state_d;
    logic              load_done_q,  load_done_d;
    logic              data_valid_q, data_valid_d;
    logic              oor_err_q,    oor_err_d;
    logic              mem_rd_req_q, mem_rd_req_d;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic [DATA_W-1:0] in_db_q,      in_db_d;
    logic [16:0]       req_count_q,  req_count_d;
    // Data captured when ack and valid coincide; published one cycle later.
    logic [DATA_W-1:0] buf_q,        buf_d;
    // Remembers that the pending delivery is an out-of-range answer.
    logic              oor_q,        oor_d;

    logic              in_range_s;
    logic [ADDR_W-1:0] chunk_addr_s;

    assign in_range_s   = ({1'b0, bus.outAddress} < DB_LIMIT);
    assign chunk_addr_s = BASE_ADDR + {bus.outAddress[ADDR_W-7:0], 6'b000000};

    // Next-state and output computation; stop overrides every state.
    always_comb begin
        state_d       = state_q;
        load_done_d   = 1'b0;
        data_valid_d  = 1'b0;
        oor_err_d     = 1'b0;
        mem_rd_req_d  = mem_rd_req_q;
        mem_rd_addr_d = mem_rd_addr_q;
        in_db_d       = in_db_q;
        req_count_d   = req_count_q;
        buf_d         = buf_q;
        oor_d         = oor_q;
        if (bus.stop) begin
            state_d      = ST_IDLE;
            mem_rd_req_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.load) begin
                        if (in_range_s) begin
                            state_d       = ST_REQ;
                            mem_rd_addr_d = chunk_addr_s;
                            mem_rd_req_d  = 1'b1;
                            oor_d         = 1'b0;
                        end else begin
                            state_d     = ST_DELIVER;
                            load_done_d = 1'b1;
                            oor_d       = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.memRdAck) begin
                        mem_rd_req_d = 1'b0;
                        load_done_d  = 1'b1;
                        if (bus.memRdValid) begin
                            buf_d   = bus.memRdData;
                            oor_d   = 1'b0;
                            state_d = ST_DELIVER;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_WAIT: begin
                    if (bus.memRdValid) begin
                        in_db_d      = bus.memRdData;
                        data_valid_d = 1'b1;
                        req_count_d  = req_count_q + 17'd1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                ST_DELIVER: begin
                    data_valid_d = 1'b1;
                    oor_err_d    = oor_q;
                    in_db_d      = oor_q ? {DATA_W{1'b0}} : buf_q;
                    req_count_d  = req_count_q + 17'd1;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d      = ST_IDLE;
                    mem_rd_req_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            load_done_q   <= 1'b0;
            data_valid_q  <= 1'b0;
            oor_err_q     <= 1'b0;
            mem_rd_req_q  <= 1'b0;
            mem_rd_addr_q <= {ADDR_W{1'b0}};
            in_db_q       <= {DATA_W{1'b0}};
            req_count_q   <= 17'd0;
            buf_q         <= {DATA_W{1'b0}};
            oor_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_done_q   <= load_done_d;
            data_valid_q  <= data_valid_d;
            oor_err_q     <= oor_err_d;
            mem_rd_req_q  <= mem_rd_req_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            in_db_q       <= in_db_d;
            req_count_q   <= req_count_d;
            buf_q         <= buf_d;
            oor_q         <= oor_d;
        end
    end

    assign bus.loadDone  = load_done_q;
    assign bus.dataValid = data_valid_q;
    assign bus.oorErr    = oor_err_q;
    assign bus.memRdReq  = mem_rd_req_q;
    assign bus.memRdAddr = mem_rd_addr_q;
    assign bus.inDB      = in_db_q;
    assign bus.reqCount  = req_count_q;

endmodule
